can_error_frame_ctrl: RTL and testbench

Sequencer that transmits CAN error frames and overload frames. It sits beside `can_error_detection`: any of that block's five error pulses, or an overload request, starts a frame. The block then drives the error/overload flag, handles flag superposition and the delimiter, and returns `dominant_after_flag` pulses to `can_error_detection` for counter updates. Its `ef_tx_bit`/`ef_tx_active` pair overrides the normal transmitter's bit while a frame is in progress.

---
 rtl/can_error_frame_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_can_error_frame_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_error_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : can_error_frame_ctrl
// Description : CAN error/overload frame sequencer (flag, superposition,
//               delimiter) with dominant-after-flag reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module can_error_frame_ctrl #(
    parameter int FLAG_LEN  = 6,
    parameter int DELIM_LEN = 8,
    parameter int DOM_STEP  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_point,
    input  logic       rx_bit,
    input  logic       bit_error,
    input  logic       stuff_error,
    input  logic       crc_error,
    input  logic       form_error,
    input  logic       ack_error,
    input  logic       overload_request,
    input  logic       error_passive,
    input  logic       bus_off,
    output logic       ef_tx_bit,
    output logic       ef_tx_active,
    output logic       ef_busy,
    output logic       dominant_after_flag,
    output logic       delim_error,
    output logic       error_frame_done,
    output logic       overload_frame_done,
    output logic [2:0] state
);

    localparam int c_MAX_FD  = (FLAG_LEN > DELIM_LEN) ? FLAG_LEN : DELIM_LEN;
    localparam int c_MAX_LEN = (c_MAX_FD > DOM_STEP) ? c_MAX_FD : DOM_STEP;
    localparam int c_CW      = $clog2(c_MAX_LEN + 1);

    localparam logic [c_CW-1:0] c_FLAG_LEN  = c_CW'(FLAG_LEN);
    localparam logic [c_CW-1:0] c_DELIM_LEN = c_CW'(DELIM_LEN);
    localparam logic [c_CW-1:0] c_DOM_STEP  = c_CW'(DOM_STEP);
    localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);
    localparam logic            c_KIND_ERR  = 1'b0;
    localparam logic            c_KIND_OVL  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ERR_FLAG = 3'd1,
        S_OVL_FLAG = 3'd2,
        S_WAIT_REC = 3'd3,
        S_DELIM    = 3'd4,
        S_BUS_OFF  = 3'd5
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [c_CW-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [c_CW-1:0]   r_dom_cnt, w_dom_cnt_nxt;
    logic              r_dom_seen, w_dom_seen_nxt;
    logic              r_kind, w_kind_nxt;
    logic              r_passive_flag, w_passive_nxt;
    logic              r_prev_rx, w_prev_rx_nxt;
    logic              r_ef_tx_bit, w_ef_tx_bit_nxt;
    logic              r_ef_tx_active, w_ef_tx_active_nxt;
    logic              r_daf, w_daf_nxt;
    logic              r_delim_err, w_delim_err_nxt;
    logic              r_err_done, w_err_done_nxt;
    logic              r_ovl_done, w_ovl_done_nxt;

    logic              w_any_err;
    logic              w_start_err;
    logic              w_ovl_abort;
    logic [c_CW-1:0]   w_bit_inc;
    logic [c_CW-1:0]   w_dom_inc;

    assign w_any_err   = bit_error | stuff_error | crc_error | form_error | ack_error;
    assign w_ovl_abort = w_any_err && (r_kind == c_KIND_OVL);
    assign w_bit_inc   = r_bit_cnt + c_ONE;
    assign w_dom_inc   = r_dom_cnt + c_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_bit_cnt      <= '0;
            r_dom_cnt      <= '0;
            r_dom_seen     <= 1'b0;
            r_kind         <= c_KIND_ERR;
            r_passive_flag <= 1'b0;
            r_prev_rx      <= 1'b1;
            r_ef_tx_bit    <= 1'b1;
            r_ef_tx_active <= 1'b0;
            r_daf          <= 1'b0;
            r_delim_err    <= 1'b0;
            r_err_done     <= 1'b0;
            r_ovl_done     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_bit_cnt      <= w_bit_cnt_nxt;
            r_dom_cnt      <= w_dom_cnt_nxt;
            r_dom_seen     <= w_dom_seen_nxt;
            r_kind         <= w_kind_nxt;
            r_passive_flag <= w_passive_nxt;
            r_prev_rx      <= w_prev_rx_nxt;
            r_ef_tx_bit    <= w_ef_tx_bit_nxt;
            r_ef_tx_active <= w_ef_tx_active_nxt;
            r_daf          <= w_daf_nxt;
            r_delim_err    <= w_delim_err_nxt;
            r_err_done     <= w_err_done_nxt;
            r_ovl_done     <= w_ovl_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_dom_cnt_nxt   = r_dom_cnt;
        w_dom_seen_nxt  = r_dom_seen;
        w_kind_nxt      = r_kind;
        w_passive_nxt   = r_passive_flag;
        w_prev_rx_nxt   = r_prev_rx;
        w_daf_nxt       = 1'b0;
        w_delim_err_nxt = 1'b0;
        w_err_done_nxt  = 1'b0;
        w_ovl_done_nxt  = 1'b0;
        w_start_err     = 1'b0;

        if (bus_off) begin
            w_state_nxt    = S_BUS_OFF;
            w_bit_cnt_nxt  = '0;
            w_dom_cnt_nxt  = '0;
            w_dom_seen_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_err) begin
                        w_start_err = 1'b1;
                    end else if (overload_request) begin
                        w_state_nxt    = S_OVL_FLAG;
                        w_kind_nxt     = c_KIND_OVL;
                        w_bit_cnt_nxt  = '0;
                        w_dom_cnt_nxt  = '0;
                        w_dom_seen_nxt = 1'b0;
                    end
                end
                S_ERR_FLAG: begin
                    if (sample_point) begin
                        // A passive flag ends only after FLAG_LEN equal bits seen on the bus
                        if (r_passive_flag) begin
                            if ((r_bit_cnt == '0) || (rx_bit != r_prev_rx)) begin
                                w_bit_cnt_nxt = c_ONE;
                            end else begin
                                w_bit_cnt_nxt = w_bit_inc;
                            end
                            w_prev_rx_nxt = rx_bit;
                        end else begin
                            w_bit_cnt_nxt = w_bit_inc;
                        end
                        if (w_bit_cnt_nxt == c_FLAG_LEN) begin
                            w_state_nxt = S_WAIT_REC;
                        end
                    end
                end
                S_OVL_FLAG: begin
                    if (w_any_err) begin
                        w_start_err = 1'b1;
                    end else if (sample_point) begin
                        w_bit_cnt_nxt = w_bit_inc;
                        if (w_bit_inc == c_FLAG_LEN) begin
                            w_state_nxt = S_WAIT_REC;
                        end
                    end
                end
                S_WAIT_REC: begin
                    if (w_ovl_abort) begin
                        w_start_err = 1'b1;
                    end else if (sample_point) begin
                        if (!rx_bit) begin
                            if ((r_kind == c_KIND_ERR) && !r_dom_seen) begin
                                w_daf_nxt      = 1'b1;
                                w_dom_seen_nxt = 1'b1;
                                w_dom_cnt_nxt  = '0;
                            end else if (r_dom_seen) begin
                                if (w_dom_inc == c_DOM_STEP) begin
                                    w_daf_nxt     = 1'b1;
                                    w_dom_cnt_nxt = '0;
                                end else begin
                                    w_dom_cnt_nxt = w_dom_inc;
                                end
                            end
                        end else begin
                            // The first recessive bit already counts as delimiter bit one
                            w_state_nxt   = S_DELIM;
                            w_bit_cnt_nxt = c_ONE;
                        end
                    end
                end
                S_DELIM: begin
                    if (w_ovl_abort) begin
                        w_start_err = 1'b1;
                    end else if (sample_point) begin
                        if (rx_bit) begin
                            w_bit_cnt_nxt = w_bit_inc;
                            if (w_bit_inc == c_DELIM_LEN) begin
                                w_err_done_nxt = (r_kind == c_KIND_ERR);
                                w_ovl_done_nxt = (r_kind == c_KIND_OVL);
                                w_state_nxt    = S_IDLE;
                                w_bit_cnt_nxt  = '0;
                            end
                        end else begin
                            w_delim_err_nxt = 1'b1;
                            w_start_err     = 1'b1;
                        end
                    end
                end
                S_BUS_OFF: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase

            if (w_start_err) begin
                w_state_nxt    = S_ERR_FLAG;
                w_kind_nxt     = c_KIND_ERR;
                w_passive_nxt  = error_passive;
                w_bit_cnt_nxt  = '0;
                w_dom_cnt_nxt  = '0;
                w_dom_seen_nxt = 1'b0;
            end
        end

        w_ef_tx_active_nxt = (w_state_nxt == S_ERR_FLAG) || (w_state_nxt == S_OVL_FLAG) ||
                             (w_state_nxt == S_WAIT_REC) || (w_state_nxt == S_DELIM);
        w_ef_tx_bit_nxt    = !(((w_state_nxt == S_ERR_FLAG) && !w_passive_nxt) ||
                               (w_state_nxt == S_OVL_FLAG));
    end

    assign state               = r_state;
    assign ef_tx_bit           = r_ef_tx_bit;
    assign ef_tx_active        = r_ef_tx_active;
    assign ef_busy             = r_ef_tx_active;
    assign dominant_after_flag = r_daf;
    assign delim_error         = r_delim_err;
    assign error_frame_done    = r_err_done;
    assign overload_frame_done = r_ovl_done;

endmodule
`default_nettype wire

// File: tb/tb_can_error_frame_ctrl.sv
`default_nettype none
// Randomized scoreboard bench: frame scenarios predict pulse events by cycle,
// a negedge monitor matches DUT pulses against them.
module tb_can_error_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_point = 1'b0;
    logic       rx_bit = 1'b1;
    logic       bit_error = 1'b0, stuff_error = 1'b0, crc_error = 1'b0;
    logic       form_error = 1'b0, ack_error = 1'b0;
    logic       overload_request = 1'b0;
    logic       error_passive = 1'b0;
    logic       bus_off = 1'b0;
    logic       ef_tx_bit, ef_tx_active, ef_busy;
    logic       dominant_after_flag, delim_error;
    logic       error_frame_done, overload_frame_done;
    logic [2:0] state;

    can_error_frame_ctrl #(.FLAG_LEN(6), .DELIM_LEN(8), .DOM_STEP(8)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .sample_point        (sample_point),
        .rx_bit              (rx_bit),
        .bit_error           (bit_error),
        .stuff_error         (stuff_error),
        .crc_error           (crc_error),
        .form_error          (form_error),
        .ack_error           (ack_error),
        .overload_request    (overload_request),
        .error_passive       (error_passive),
        .bus_off             (bus_off),
        .ef_tx_bit           (ef_tx_bit),
        .ef_tx_active        (ef_tx_active),
        .ef_busy             (ef_busy),
        .dominant_after_flag (dominant_after_flag),
        .delim_error         (delim_error),
        .error_frame_done    (error_frame_done),
        .overload_frame_done (overload_frame_done),
        .state               (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    localparam logic [3:0] EV_DAF   = 4'b1000;
    localparam logic [3:0] EV_DERR  = 4'b0100;
    localparam logic [3:0] EV_EDONE = 4'b0010;
    localparam logic [3:0] EV_ODONE = 4'b0001;

    typedef struct {
        logic [3:0] ev;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    logic pq[$];

    // Pulse monitor: every pulse the DUT shows must be the next predicted event
    always @(negedge clk) begin
        logic [3:0] ev;
        exp_t       e;
        ev = {dominant_after_flag, delim_error, error_frame_done, overload_frame_done};
        if (!rst && ev != 4'b0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got %b at cycle %0d, want none", ev, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.ev != ev || e.cyc != cyc) begin
                    bad++;
                    $display("FAIL pulse: got %b at cycle %0d, want %b at cycle %0d", ev, cyc, e.ev, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic do_sample(input logic b, input logic [3:0] ev);
        exp_t e;
        repeat ($urandom_range(0, 2)) tick();
        sample_point = 1'b1;
        rx_bit       = b;
        if (ev != 4'b0) begin
            e.ev  = ev;
            e.cyc = cyc + 1;
            exp_q.push_back(e);
        end
        tick();
        sample_point = 1'b0;
    endtask

    task automatic set_err(input int which, input logic v);
        case (which)
            0: bit_error   = v;
            1: stuff_error = v;
            2: crc_error   = v;
            3: form_error  = v;
            default: ack_error = v;
        endcase
    endtask

    task automatic start_err(input int which, input logic with_ovl);
        set_err(which, 1'b1);
        overload_request = with_ovl;
        tick();
        set_err(which, 1'b0);
        overload_request = 1'b0;
        chk("err_entry_state", state, 1);
        chk("err_entry_active", ef_tx_active, 1);
        chk("err_entry_busy", ef_busy, 1);
    endtask

    task automatic check_idle(input string name);
        chk({name, "_state"}, state, 0);
        chk({name, "_active"}, ef_tx_active, 0);
        chk({name, "_busy"}, ef_busy, 0);
        chk({name, "_txbit"}, ef_tx_bit, 1);
    endtask

    task automatic drain();
        tick();
        tick();
        chk("pending_pulses", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Error frame from flag onwards; passive flags consume pq until a run of 6 equal bits
    task automatic err_body(input int sup_in, input int viol_in, input logic inj);
        int   sup  = sup_in;
        int   viol = viol_in;
        logic again;
        do begin
            logic pas;
            again = 1'b0;
            pas   = error_passive;
            if (pas) begin
                int   run  = 0;
                logic prev = 1'b0;
                for (int i = 0; i < pq.size(); i++) begin
                    chk("pflag_txbit", ef_tx_bit, 1);
                    do_sample(pq[i], 4'b0);
                    run  = (i > 0 && pq[i] == prev) ? run + 1 : 1;
                    prev = pq[i];
                    if (run == 6) break;
                    chk("pflag_state", state, 1);
                end
            end else begin
                for (int i = 0; i < 6; i++) begin
                    chk("aflag_state", state, 1);
                    chk("aflag_txbit", ef_tx_bit, 0);
                    do_sample(1'b0, 4'b0);
                end
            end
            chk("flag_end_state", state, 3);
            chk("wait_txbit", ef_tx_bit, 1);
            for (int i = 1; i <= sup; i++) begin
                do_sample(1'b0, (i == 1 || (i - 1) % 8 == 0) ? EV_DAF : 4'b0);
            end
            for (int p = 1; p <= 8; p++) begin
                if (inj && p == 3) begin
                    set_err($urandom_range(0, 4), 1'b1);
                    tick();
                    {bit_error, stuff_error, crc_error, form_error, ack_error} = 5'b0;
                end
                if (p == viol) begin
                    error_passive = 1'b0;
                    do_sample(1'b0, EV_DERR);
                    chk("delim_viol_state", state, 1);
                    chk("delim_viol_txbit", ef_tx_bit, 0);
                    again = 1'b1;
                    break;
                end
                do_sample(1'b1, (p == 8) ? EV_EDONE : 4'b0);
                if (p < 8) chk("delim_state", state, 4);
            end
            if (!again) check_idle("err_done");
            sup  = 0;
            viol = 0;
        end while (again);
    endtask

    task automatic ovl_frame(input int abort_at);
        overload_request = 1'b1;
        tick();
        overload_request = 1'b0;
        chk("ovl_entry_state", state, 2);
        chk("ovl_entry_txbit", ef_tx_bit, 0);
        chk("ovl_entry_active", ef_tx_active, 1);
        for (int i = 1; i <= 14; i++) begin
            if (i == abort_at) begin
                error_passive = 1'b0;
                form_error    = 1'b1;
                tick();
                form_error    = 1'b0;
                chk("ovl_abort_state", state, 1);
                err_body(0, 0, 1'b0);
                return;
            end
            if (i <= 6) begin
                do_sample(1'b0, 4'b0);
                if (i == 6) chk("ovl_flag_end_state", state, 3);
            end else begin
                do_sample(1'b1, (i == 14) ? EV_ODONE : 4'b0);
            end
        end
        check_idle("ovl_done");
    endtask

    task automatic make_passive_bits();
        logic v;
        pq.delete();
        repeat ($urandom_range(0, 4)) pq.push_back(1'($urandom_range(0, 1)));
        v = 1'($urandom_range(0, 1));
        repeat (6) pq.push_back(v);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        chk("reset_daf", dominant_after_flag, 0);
        chk("reset_done", error_frame_done | overload_frame_done | delim_error, 0);
        rst = 1'b0;
        tick();

        // Active error frame, no superposition
        error_passive = 1'b0;
        start_err(0, 1'b0);
        err_body(0, 0, 1'b0);
        drain();

        // Superposition of 17 dominant bits
        start_err(1, 1'b0);
        err_body(17, 0, 1'b0);
        drain();

        // Passive flag with the 0,1,1,1,1,1,1 pattern
        error_passive = 1'b1;
        pq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        start_err(2, 1'b0);
        err_body(0, 0, 1'b0);
        error_passive = 1'b0;
        drain();

        // Overload frame, then overload aborted by an error during its flag
        ovl_frame(0);
        drain();
        ovl_frame(3);
        drain();

        // Error and overload request together favour the error frame
        start_err(4, 1'b1);
        err_body(2, 0, 1'b0);
        drain();

        // Delimiter violation at delimiter sample 4
        start_err(3, 1'b0);
        err_body(0, 4, 1'b0);
        drain();

        // Bus-off mid-flag
        start_err(0, 1'b0);
        do_sample(1'b0, 4'b0);
        do_sample(1'b0, 4'b0);
        bus_off = 1'b1;
        tick();
        chk("busoff_state", state, 5);
        chk("busoff_active", ef_tx_active, 0);
        chk("busoff_txbit", ef_tx_bit, 1);
        chk("busoff_busy", ef_busy, 0);
        bit_error        = 1'b1;
        overload_request = 1'b1;
        repeat (3) tick();
        bit_error        = 1'b0;
        overload_request = 1'b0;
        chk("busoff_hold_state", state, 5);
        bus_off = 1'b0;
        tick();
        check_idle("busoff_exit");
        drain();

        // Reset asserted mid-delimiter
        start_err(1, 1'b0);
        repeat (6) do_sample(1'b0, 4'b0);
        repeat (3) do_sample(1'b1, 4'b0);
        chk("pre_reset_state", state, 4);
        rst = 1'b1;
        #1;
        check_idle("async_reset");
        chk("async_reset_pulses",
            {dominant_after_flag, delim_error, error_frame_done, overload_frame_done}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check_idle("after_reset");
        drain();

        // Randomized scenarios
        for (int n = 0; n < 30; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            if (kind == 2) begin
                ovl_frame($urandom_range(0, 1) ? $urandom_range(1, 14) : 0);
            end else begin
                error_passive = (kind == 1);
                if (kind == 1) make_passive_bits();
                start_err($urandom_range(0, 4), 1'($urandom_range(0, 1)));
                err_body($urandom_range(0, 20),
                         $urandom_range(0, 1) ? $urandom_range(2, 8) : 0,
                         1'($urandom_range(0, 1)));
                error_passive = 1'b0;
            end
            drain();
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
